// File: rtl/ins_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and the
// instruction memory (slave): address/read-strobe out, data/valid back.
interface ins_fetch_if #(
  parameter int INS_W = 8
);
  logic [7:0]       mem_addr;
  logic             mem_rd;
  logic [INS_W-1:0] mem_data;
  logic             mem_valid;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_data,
    input  mem_valid
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_data,
    output mem_valid
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch stage: reads one instruction per PC step into the IR and
// halts on END_OPC. Optional WAIT timeout is enabled by `define FETCH_TIMEOUT_EN.
module ins_fetch #(
  parameter int               INS_W   = 8,
  parameter logic [INS_W-1:0] END_OPC = 8'hFF,
  parameter int               TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       ins_address,
  input  logic             pc_step,
  ins_fetch_if.master      mem,
  output logic [INS_W-1:0] ir,
  output logic             ir_valid,
  output logic             finish,
  output logic             busy
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic             fetch_err
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    LATCH  = 3'd3,
    DECODE = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             start_q;
  logic [7:0]       addr_q;
  logic [INS_W-1:0] data_q;
  logic             capture;
  logic             timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] wait_cnt_q;

  // Fires on the TIMEOUT-th WAIT cycle; a simultaneous mem_valid takes priority.
  assign timeout_hit = (state_q == WAIT) && !mem.mem_valid &&
                       (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Data is only accepted while a read is actually outstanding.
  assign capture = ((state_q == REQ) || (state_q == WAIT)) && mem.mem_valid;

  // The address is driven straight through in REQ so the memory sees it
  // together with mem_rd; afterwards the registered copy holds it stable.
  assign mem.mem_addr = (state_q == REQ) ? ins_address : addr_q;
  assign mem.mem_rd   = (state_q == REQ);
  assign busy         = (state_q == REQ) || (state_q == WAIT);
  assign ir_valid     = (state_q == LATCH);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next-state is defaulted to the current state before the case, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_q) state_d = REQ;
      REQ:     state_d = mem.mem_valid ? LATCH : WAIT;
      WAIT: begin
        if (mem.mem_valid)    state_d = LATCH;
        else if (timeout_hit) state_d = HALT;
      end
      LATCH:   state_d = DECODE;
      DECODE: begin
        if (ir == END_OPC) state_d = HALT;
        else if (pc_step)  state_d = REQ;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ir      <= '0;
      finish  <= 1'b0;
    end else begin
      start_q <= start_q | enable;
      if (state_q == REQ)   addr_q <= ins_address;
      if (capture)          data_q <= mem.mem_data;
      if (state_q == LATCH) ir     <= data_q;
      if (((state_q == DECODE) && (ir == END_OPC)) || timeout_hit)
        finish <= 1'b1;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      fetch_err  <= 1'b0;
    end else begin
      if (state_q == REQ)       wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (timeout_hit)          fetch_err  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: latency cases, END halt, stray pc_step,
// mid-fetch reset and (with FETCH_TIMEOUT_EN) the WAIT timeout.
module tb_ins_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] ins_address = 8'h00;
  logic       pc_step = 1'b0;
  logic [7:0] ir;
  logic       ir_valid, finish, busy;
`ifdef FETCH_TIMEOUT_EN
  logic       fetch_err;
`endif

  int tests = 0;
  int failures = 0;

  ins_fetch_if #(.INS_W(8)) mem_bus ();

  ins_fetch #(.INS_W(8), .END_OPC(8'hFF), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .ins_address(ins_address),
    .pc_step    (pc_step),
    .mem        (mem_bus),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .finish     (finish),
    .busy       (busy)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},   {24'h0, mem_bus.mem_addr}, 32'h0);
    check({tag, "_rd"},     {31'h0, mem_bus.mem_rd},   32'h0);
    check({tag, "_ir"},     {24'h0, ir},               32'h0);
    check({tag, "_irv"},    {31'h0, ir_valid},         32'h0);
    check({tag, "_finish"}, {31'h0, finish},           32'h0);
    check({tag, "_busy"},   {31'h0, busy},             32'h0);
  endtask

  // Precondition: the FSM has just entered REQ. Returns with the FSM in DECODE.
  task automatic do_fetch(input string tag, input logic [7:0] addr, input logic [7:0] data,
                          input int lat, input bit step_in_wait);
    check({tag, "_req_rd"},   {31'h0, mem_bus.mem_rd},   32'h1);
    check({tag, "_req_addr"}, {24'h0, mem_bus.mem_addr}, {24'h0, addr});
    check({tag, "_req_busy"}, {31'h0, busy},             32'h1);
    mem_bus.mem_data = data;
    if (lat == 0) begin
      mem_bus.mem_valid = 1'b1;
      tick();
    end else begin
      tick();
      for (int i = 1; i <= lat; i++) begin
        check({tag, "_wait_busy"}, {31'h0, busy},           32'h1);
        check({tag, "_wait_rd"},   {31'h0, mem_bus.mem_rd}, 32'h0);
        check({tag, "_wait_irv"},  {31'h0, ir_valid},       32'h0);
        pc_step = step_in_wait && (i == 1);
        mem_bus.mem_valid = (i == lat);
        tick();
      end
    end
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_data  = 8'h00;
    pc_step = 1'b0;
    check({tag, "_latch_irv"},  {31'h0, ir_valid}, 32'h1);
    check({tag, "_latch_busy"}, {31'h0, busy},     32'h0);
    tick();
    check({tag, "_dec_ir"},  {24'h0, ir},       {24'h0, data});
    check({tag, "_dec_irv"}, {31'h0, ir_valid}, 32'h0);
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check("start_idle_busy", {31'h0, busy}, 32'h0);
    tick();
  endtask

  task automatic step_pc(input logic [7:0] addr);
    ins_address = addr;
    pc_step = 1'b1;
    tick();
    pc_step = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_data  = 8'h00;
    tick();
    tick();
    check_reset("rst");
    rst_n = 1'b1;
    tick();
    check_reset("post_rst_no_enable");

    // Zero-latency fetch of 8'h12 at address 0.
    ins_address = 8'h00;
    start_run();
    do_fetch("f0", 8'h00, 8'h12, 0, 1'b0);
    check("f0_finish", {31'h0, finish}, 32'h0);

    // Three-cycle memory latency, stray pc_step during WAIT.
    step_pc(8'h01);
    do_fetch("f1", 8'h01, 8'h34, 3, 1'b1);
    ins_address = 8'h02;
    for (int i = 0; i < 3; i++) begin
      check("f1_hold_rd",   {31'h0, mem_bus.mem_rd},   32'h0);
      check("f1_hold_busy", {31'h0, busy},             32'h0);
      check("f1_hold_addr", {24'h0, mem_bus.mem_addr}, 32'h01);
      tick();
    end
    check("f1_hold_ir", {24'h0, ir}, 32'h34);

    // END opcode: halt with finish, no further reads, pc_step ignored.
    step_pc(8'h02);
    do_fetch("f2", 8'h02, 8'hFF, 1, 1'b0);
    check("f2_finish_pre", {31'h0, finish}, 32'h0);
    tick();
    check("halt_finish", {31'h0, finish}, 32'h1);
    ins_address = 8'h03;
    for (int i = 0; i < 4; i++) begin
      pc_step = 1'b1;
      mem_bus.mem_valid = 1'b1;
      mem_bus.mem_data  = 8'hAA;
      tick();
      check("halt_rd",     {31'h0, mem_bus.mem_rd}, 32'h0);
      check("halt_busy",   {31'h0, busy},           32'h0);
      check("halt_ir",     {24'h0, ir},             32'hFF);
      check("halt_irv",    {31'h0, ir_valid},       32'h0);
      check("halt_finish", {31'h0, finish},         32'h1);
    end
    pc_step = 1'b0;
    mem_bus.mem_valid = 1'b0;

    // Reset asserted during WAIT, then a late mem_valid.
    pulse_reset();
    check_reset("rst2");
    ins_address = 8'h05;
    start_run();
    check("r_req_rd", {31'h0, mem_bus.mem_rd}, 32'h1);
    tick();
    check("r_wait_busy", {31'h0, busy}, 32'h1);
    check("r_wait_addr", {24'h0, mem_bus.mem_addr}, 32'h05);
    rst_n = 1'b0;
    #1;
    check_reset("r_async");
    tick();
    rst_n = 1'b1;
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_data  = 8'h55;
    tick();
    tick();
    mem_bus.mem_valid = 1'b0;
    check_reset("r_late_valid");

`ifdef FETCH_TIMEOUT_EN
    // Timeout: 15 WAIT cycles without data halts with fetch_err, ir unchanged.
    pulse_reset();
    ins_address = 8'h06;
    start_run();
    do_fetch("t0", 8'h06, 8'h77, 0, 1'b0);
    step_pc(8'h07);
    check("t_req_rd", {31'h0, mem_bus.mem_rd}, 32'h1);
    tick();
    for (int i = 1; i <= 15; i++) begin
      check("t_wait_busy", {31'h0, busy},      32'h1);
      check("t_wait_err",  {31'h0, fetch_err}, 32'h0);
      check("t_wait_irv",  {31'h0, ir_valid},  32'h0);
      tick();
    end
    check("t_err",    {31'h0, fetch_err}, 32'h1);
    check("t_finish", {31'h0, finish},    32'h1);
    check("t_busy",   {31'h0, busy},      32'h0);
    check("t_irv",    {31'h0, ir_valid},  32'h0);
    check("t_ir",     {24'h0, ir},        32'h77);
    tick();
    check("t_halt_rd", {31'h0, mem_bus.mem_rd}, 32'h0);

    // mem_valid on the 15th WAIT cycle wins over the timeout.
    pulse_reset();
    ins_address = 8'h08;
    start_run();
    do_fetch("t1", 8'h08, 8'h9C, 15, 1'b0);
    check("t1_err",    {31'h0, fetch_err}, 32'h0);
    check("t1_finish", {31'h0, finish},    32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
